// File: rtl/opad_ser.sv
// opad_ser: output-pad serializer; valid/ready word load, one-word hold buffer, 1 bit/clk out.
// Build option OPAD_SER_MSB_FIRST_EN: wire order MSB first (default LSB first).
module opad_ser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             outpad,
  output logic             frame,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;

  logic [WIDTH-1:0] shreg, hold;
  logic [CW-1:0]    cnt;
  logic             hold_full, take, last, cur_bit;
  logic             sh_ld, sh_from_hold, hold_ld;

  assign load_ready = !hold_full;
  assign take       = load_valid && load_ready;
  assign last       = (cnt == LAST);

`ifdef OPAD_SER_MSB_FIRST_EN
  assign cur_bit = shreg[LAST - cnt];
`else
  assign cur_bit = shreg[cnt];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // The last-bit cycle refills shreg (hold first, then a direct accept) so words stream gap-free.
  always_comb begin
    state_d      = state;
    sh_ld        = 1'b0;
    sh_from_hold = 1'b0;
    hold_ld      = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          sh_ld   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          if (hold_full) begin
            sh_ld        = 1'b1;
            sh_from_hold = 1'b1;
          end else if (take) begin
            sh_ld = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (take) begin
          hold_ld = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      outpad    <= 1'b0;
      frame     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      outpad <= (state == SHIFT) && cur_bit;
      frame  <= (state == SHIFT) && (cnt == '0);
      busy   <= (state == SHIFT);
      if (sh_ld) shreg <= sh_from_hold ? hold : din;
      if (state == SHIFT) cnt <= last ? '0 : cnt + 1'b1;
      if (hold_ld) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (sh_from_hold) begin
        hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: doc/opad_ser.md
# opad_ser

Output-pad serializer cell: the transmit-side counterpart of the input pad. It accepts parallel words from fabric logic over a valid/ready handshake and shifts them out one bit per clock onto the `outpad` pin. A one-word holding buffer lets back-to-back words stream with no idle cycles. It is instantiated directly behind an output pad site in the I/O tile model.

## Interface
- `WIDTH`, default 4: bits per word; legal range 2..8.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  WIDTH  parallel word to transmit.
- `load_valid`  input  1  `din` is valid this cycle.
- `load_ready`  output  1  cell can accept a word this cycle. Equals `!hold_full`. Value 1 in reset.
- `outpad`  output  1  serial pad output, registered. Value 0 in reset and while idle.
- `frame`  output  1  registered; high exactly in the cycle `outpad` carries bit 0 (first bit) of a word. Value 0 in reset.
- `busy`  output  1  registered; high while a word is being shifted out. Value 0 in reset.

## Operation
- Transfer occurs on a rising edge when `load_valid && load_ready`.
- State:
  - `shreg` (WIDTH bits)
  - `cnt` (bit index, `$clog2(WIDTH)` bits)
  - `hold` plus `hold_full`
  - FSM with states IDLE and SHIFT.
- IDLE:
  - An accepted word loads straight into `shreg`.
  - Next state is SHIFT, with `cnt`=0.
- SHIFT:
  - Each cycle, `outpad` <= current bit and `cnt` increments.
  - The last bit is sent when `cnt`==WIDTH-1. On that cycle, the next word comes from `hold` if `hold_full`. Otherwise it comes from an accepted word in the same cycle. In either case `cnt`=0 and the state stays SHIFT.
  - If no next word is available, the next state is IDLE.
- While in SHIFT and not at the last bit, an accepted word goes to `hold`, setting `hold_full`=1.
- `hold_full` clears when `hold` is moved into `shreg`. It cannot also be set in that same cycle, because `load_ready` is 0 while `hold_full`=1.
- `load_valid` low with `load_ready` high: no state change. `din` is ignored unless a transfer occurs.
- Reset mid-word: everything clears immediately.
  - The partial word and any held word are discarded.
  - `outpad`, `frame` and `busy` drop to 0 asynchronously.
  - No bits resume after reset release.

## Timing
- Latency: a word accepted at edge N drives bit 0 on `outpad` (with `frame`=1, `busy`=1) from edge N+1. Bit k appears from edge N+1+k.
- One word occupies exactly WIDTH consecutive cycles on `outpad`.
- Streaming: with the next word available by the last-bit cycle, bit 0 of that word follows bit WIDTH-1 of the previous word on the very next cycle. There is no gap.
- Underrun: if no word is available at the last bit, `outpad` returns to 0 and `busy` to 0 one cycle after the last bit.
- Sustained throughput: one word per WIDTH cycles. `load_ready` deasserts at most WIDTH-1 cycles per word under continuous `load_valid`.
- `load_ready` is combinational from `hold_full` only. It has no path from `load_valid`.

## Configuration
- Macro `OPAD_SER_MSB_FIRST_EN`.
- Defined: bit order is MSB first, so bit 0 on the wire is `din[WIDTH-1]`.
- Undefined (default): LSB first, so bit 0 on the wire is `din[0]`.
- `frame`, latency and handshake are identical in both builds.

## Test plan
- Reset: assert `rst` mid-stream at an arbitrary phase -> `outpad`=0, `frame`=0, `busy`=0 and `load_ready`=1 immediately. After release, no residual bits are sent.
- Single word, WIDTH=4, `din`=4'b1011 accepted at edge N:
  - LSB build: `outpad` = 1,1,0,1 in cycles N+1..N+4, with `frame` only at N+1.
  - Next cycle: `busy`=0, `outpad`=0.
- Back-to-back words 4'hA then 4'h5 with `load_valid` held high -> 8 contiguous bits 0,1,0,1,1,0,1,0 with no gap. `frame` at cycles 1 and 5. `load_ready` is low while `hold` is full.
- Accept in the same cycle as the last bit with `hold` empty:
  - Word 4'hF is offered exactly at the last bit of 4'h0.
  - Required: it loads directly into `shreg`, and `outpad` = 0,0,0,0,1,1,1,1 contiguously.
- MSB-first build (`OPAD_SER_MSB_FIRST_EN`), `din`=4'b1000 -> `outpad` = 1,0,0,0.
- WIDTH=8 stream of 16 random words with random `load_valid` gaps -> the scoreboard matches every bit. `frame` count is 16. `busy` is low only during underruns.
